rob_multi_commit: RTL

- Parametrised reorder buffer; successor of the single-commit ROB.
- Sits between decoder/issue, reservation-station ALU, load-store buffer (LSB), register file and instruction fetcher.
- Tracks in-flight instructions in program order and commits up to two per cycle.
- Stores a per-entry redirect target so rollback PC is exact. Count-based full/empty.

---
 rtl/rob_multi_commit_pkg.sv | 20 ++
 rtl/rob_multi_commit_if.sv | 70 +++++++
 rtl/rob_commit_sel.sv | 52 +++++
 rtl/rob_multi_commit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rob_multi_commit_pkg.sv
// Shared definitions for the dual-commit reorder buffer.
// Provides the default widths, the opcode encodings the ROB has to tell
// apart (store, conditional branch, JALR) and a small opcode classifier.
package rob_multi_commit_pkg;

  localparam int ROB_POS_W_DEF = 4;   // log2 of ROB depth
  localparam int XLEN_DEF      = 32;  // data / address width
  localparam int REG_POS_W_DEF = 5;   // architectural register index width
  localparam int OPCODE_W_DEF  = 7;   // opcode field width

  localparam logic [6:0] OPCODE_S    = 7'b0100011;  // stores
  localparam logic [6:0] OPCODE_BR   = 7'b1100011;  // conditional branches
  localparam logic [6:0] OPCODE_JALR = 7'b1100111;  // indirect jump

  // Control-flow entries whose outcome can redirect fetch.
  function automatic logic is_ctrl(input logic [6:0] op);
    return (op == OPCODE_BR) || (op == OPCODE_JALR);
  endfunction

endpackage

// File: rtl/rob_multi_commit_if.sv
// Bundle of every non-clock/reset signal of the reorder buffer.
//   slave  : the ROB itself (receives issue / writeback / queries,
//            drives commit, predictor-update and redirect outputs)
//   master : the surrounding core (decoder, ALU, LSB, regfile, fetcher)
interface rob_multi_commit_if
  import rob_multi_commit_pkg::*;
#(
  parameter int ROB_POS_W = ROB_POS_W_DEF,
  parameter int XLEN      = XLEN_DEF,
  parameter int REG_POS_W = REG_POS_W_DEF,
  parameter int OPCODE_W  = OPCODE_W_DEF
);
  logic                   rdy;
  logic                   full;
  logic [ROB_POS_W-1:0]   nxt_rob_pos;
  // issue
  logic                   issue;
  logic [REG_POS_W-1:0]   issue_rd;
  logic [OPCODE_W-1:0]    issue_opcode;
  logic [XLEN-1:0]        issue_pc;
  logic                   issue_pred_jump;
  logic                   issue_is_ready;
  // writeback
  logic                   alu_wb;
  logic [ROB_POS_W-1:0]   alu_wb_pos;
  logic [XLEN-1:0]        alu_wb_val;
  logic                   alu_wb_jump;
  logic [XLEN-1:0]        alu_wb_target;
  logic                   lsb_wb;
  logic [ROB_POS_W-1:0]   lsb_wb_pos;
  logic [XLEN-1:0]        lsb_wb_val;
  // dependency queries
  logic [ROB_POS_W-1:0]   rs1_pos;
  logic [ROB_POS_W-1:0]   rs2_pos;
  logic                   rs1_ready;
  logic                   rs2_ready;
  logic [XLEN-1:0]        rs1_val;
  logic [XLEN-1:0]        rs2_val;
  // commit
  logic [1:0]             cm_valid;
  logic [2*ROB_POS_W-1:0] cm_pos;
  logic [1:0]             reg_we;
  logic [2*REG_POS_W-1:0] reg_rd;
  logic [2*XLEN-1:0]      reg_val;
  logic                   lsb_store;
  logic                   br_commit;
  logic                   br_jump;
  logic [XLEN-1:0]        br_pc;
  logic                   rollback;
  logic                   set_pc_en;
  logic [XLEN-1:0]        set_pc;

  modport slave (
    input  rdy, issue, issue_rd, issue_opcode, issue_pc, issue_pred_jump, issue_is_ready,
    input  alu_wb, alu_wb_pos, alu_wb_val, alu_wb_jump, alu_wb_target,
    input  lsb_wb, lsb_wb_pos, lsb_wb_val, rs1_pos, rs2_pos,
    output full, nxt_rob_pos, rs1_ready, rs2_ready, rs1_val, rs2_val,
    output cm_valid, cm_pos, reg_we, reg_rd, reg_val, lsb_store,
    output br_commit, br_jump, br_pc, rollback, set_pc_en, set_pc
  );

  modport master (
    output rdy, issue, issue_rd, issue_opcode, issue_pc, issue_pred_jump, issue_is_ready,
    output alu_wb, alu_wb_pos, alu_wb_val, alu_wb_jump, alu_wb_target,
    output lsb_wb, lsb_wb_pos, lsb_wb_val, rs1_pos, rs2_pos,
    input  full, nxt_rob_pos, rs1_ready, rs2_ready, rs1_val, rs2_val,
    input  cm_valid, cm_pos, reg_we, reg_rd, reg_val, lsb_store,
    input  br_commit, br_jump, br_pc, rollback, set_pc_en, set_pc
  );
endinterface

// File: rtl/rob_commit_sel.sv
// Commit-slot selection for the dual-commit ROB (purely combinational).
// Inputs : occupancy count, fields of the head entry (slot0) and of the
//          entry after it (slot1).
// Outputs: slot0/slot1 commit enables, mispredict flag for slot0, and
//          opcode class flags used to steer the commit outputs.
module rob_commit_sel
  import rob_multi_commit_pkg::*;
#(
  parameter int ROB_POS_W = ROB_POS_W_DEF,
  parameter int XLEN      = XLEN_DEF,
  parameter int OPCODE_W  = OPCODE_W_DEF
) (
  input  logic [ROB_POS_W:0]  count,
  input  logic                ready0,
  input  logic [OPCODE_W-1:0] opcode0,
  input  logic                pred_jump0,
  input  logic                res_jump0,
  input  logic [XLEN-1:0]     pc0,
  input  logic [XLEN-1:0]     target0,
  input  logic                ready1,
  input  logic [OPCODE_W-1:0] opcode1,
  output logic                slot0,
  output logic                slot1,
  output logic                mispredict,
  output logic                store0,
  output logic                store1,
  output logic                br0
);
  logic ctrl0, ctrl1, jalr0;

  always_comb begin
    store0 = (7'(opcode0) == OPCODE_S);
    store1 = (7'(opcode1) == OPCODE_S);
    br0    = (7'(opcode0) == OPCODE_BR);
    jalr0  = (7'(opcode0) == OPCODE_JALR);
    ctrl0  = is_ctrl(7'(opcode0));
    ctrl1  = is_ctrl(7'(opcode1));

    slot0 = (count != '0) && ready0;

    // A taken JALR predicted as taken still mispredicts when the resolved
    // target differs from the fall-through the fetcher assumed.
    mispredict = slot0 && ctrl0 &&
                 ((pred_jump0 != res_jump0) ||
                  (jalr0 && pred_jump0 && (target0 != pc0 + XLEN'(4))));

    // Control flow only retires alone so a redirect never has a younger
    // instruction committed beside it; the LSB retires one store per cycle.
    slot1 = slot0 && !mispredict && (count > (ROB_POS_W+1)'(1)) && ready1 &&
            !ctrl0 && !ctrl1 && !(store0 && store1);
  end
endmodule

// File: rtl/rob_multi_commit.sv
// Parametrised reorder buffer committing up to two instructions per cycle.
// Ports: clk, rst (synchronous, active-high) and the slave side of
// rob_multi_commit_if (issue, ALU/LSB writeback, dependency queries,
// registered commit / predictor-update / fetch-redirect outputs).
// Optional build macro ROB_WB_BYPASS_EN: dependency queries also forward
// same-cycle writebacks (ALU wins over LSB on a double match).
module rob_multi_commit
  import rob_multi_commit_pkg::*;
#(
  parameter int ROB_POS_W = ROB_POS_W_DEF,
  parameter int XLEN      = XLEN_DEF,
  parameter int REG_POS_W = REG_POS_W_DEF,
  parameter int OPCODE_W  = OPCODE_W_DEF
) (
  input logic               clk,
  input logic               rst,
  rob_multi_commit_if.slave bus
);
  localparam int DEPTH = 1 << ROB_POS_W;
  localparam int CNT_W = ROB_POS_W + 1;

  // Pointers and occupancy
  logic [ROB_POS_W-1:0] head_reg, tail_reg, head1;
  logic [CNT_W-1:0]     count_reg, count_next;

  // Entry storage
  logic [DEPTH-1:0]     ready_reg;
  logic [DEPTH-1:0]     pred_jump_reg;
  logic [DEPTH-1:0]     res_jump_reg;
  logic [REG_POS_W-1:0] rd_reg     [DEPTH];
  logic [OPCODE_W-1:0]  opcode_reg [DEPTH];
  logic [XLEN-1:0]      pc_reg     [DEPTH];
  logic [XLEN-1:0]      val_reg    [DEPTH];
  logic [XLEN-1:0]      target_reg [DEPTH];

  // Registered outputs
  logic [1:0]           cm_valid_reg, reg_we_reg;
  logic [ROB_POS_W-1:0] cm_pos_reg [2];
  logic [REG_POS_W-1:0] reg_rd_reg [2];
  logic [XLEN-1:0]      reg_val_reg [2];
  logic                 lsb_store_reg, br_commit_reg, br_jump_reg;
  logic [XLEN-1:0]      br_pc_reg, set_pc_reg;
  logic                 rollback_reg, set_pc_en_reg;

  logic live, accept_issue, alu_take, lsb_take;
  logic slot0, slot1, mispredict, store0, store1, br0;

  assign head1 = head_reg + ROB_POS_W'(1);

  // Nothing is accepted while stalled or while the flush cycle is running.
  assign live         = !rst && !rollback_reg && bus.rdy;
  assign accept_issue = live && bus.issue && !bus.full;
  assign alu_take     = live && bus.alu_wb;
  assign lsb_take     = live && bus.lsb_wb;

  rob_commit_sel #(
    .ROB_POS_W(ROB_POS_W),
    .XLEN     (XLEN),
    .OPCODE_W (OPCODE_W)
  ) u_sel (
    .count     (count_reg),
    .ready0    (ready_reg[head_reg]),
    .opcode0   (opcode_reg[head_reg]),
    .pred_jump0(pred_jump_reg[head_reg]),
    .res_jump0 (res_jump_reg[head_reg]),
    .pc0       (pc_reg[head_reg]),
    .target0   (target_reg[head_reg]),
    .ready1    (ready_reg[head1]),
    .opcode1   (opcode_reg[head1]),
    .slot0     (slot0),
    .slot1     (slot1),
    .mispredict(mispredict),
    .store0    (store0),
    .store1    (store1),
    .br0       (br0)
  );

  always_comb begin
    count_next = count_reg + CNT_W'(accept_issue) - CNT_W'(slot0) - CNT_W'(slot1);
  end

  // Control state: pointers, ready bits and registered outputs.
  always_ff @(posedge clk) begin
    if (rst || rollback_reg) begin
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      ready_reg     <= '0;
      cm_valid_reg  <= '0;
      reg_we_reg    <= '0;
      lsb_store_reg <= 1'b0;
      br_commit_reg <= 1'b0;
      br_jump_reg   <= 1'b0;
      br_pc_reg     <= '0;
      rollback_reg  <= 1'b0;
      set_pc_en_reg <= 1'b0;
      set_pc_reg    <= '0;
      for (int s = 0; s < 2; s++) begin
        cm_pos_reg[s]  <= '0;
        reg_rd_reg[s]  <= '0;
        reg_val_reg[s] <= '0;
      end
    end else if (!bus.rdy) begin
      cm_valid_reg  <= '0;
      reg_we_reg    <= '0;
      lsb_store_reg <= 1'b0;
      br_commit_reg <= 1'b0;
      set_pc_en_reg <= 1'b0;
    end else begin
      cm_valid_reg  <= {slot1, slot0};
      reg_we_reg    <= {slot1 && !store1, slot0 && !store0 && !br0};
      lsb_store_reg <= (slot0 && store0) || (slot1 && store1);
      br_commit_reg <= slot0 && br0;
      rollback_reg  <= mispredict;
      set_pc_en_reg <= mispredict;
      if (mispredict) set_pc_reg <= target_reg[head_reg];

      if (slot0) begin
        cm_pos_reg[0]     <= head_reg;
        reg_rd_reg[0]     <= rd_reg[head_reg];
        reg_val_reg[0]    <= val_reg[head_reg];
        ready_reg[head_reg] <= 1'b0;
        if (br0) begin
          br_jump_reg <= res_jump_reg[head_reg];
          br_pc_reg   <= pc_reg[head_reg];
        end
      end
      if (slot1) begin
        cm_pos_reg[1]  <= head1;
        reg_rd_reg[1]  <= rd_reg[head1];
        reg_val_reg[1] <= val_reg[head1];
        ready_reg[head1] <= 1'b0;
      end

      head_reg  <= head_reg + ROB_POS_W'(slot0) + ROB_POS_W'(slot1);
      count_reg <= count_next;
      if (accept_issue) begin
        tail_reg            <= tail_reg + ROB_POS_W'(1);
        ready_reg[tail_reg] <= bus.issue_is_ready;
      end
      if (lsb_take) ready_reg[bus.lsb_wb_pos] <= 1'b1;
      if (alu_take) ready_reg[bus.alu_wb_pos] <= 1'b1;
    end
  end

  // Entry payload: no reset needed, every field is written before use.
  always_ff @(posedge clk) begin
    if (accept_issue) begin
      rd_reg[tail_reg]        <= bus.issue_rd;
      opcode_reg[tail_reg]    <= bus.issue_opcode;
      pc_reg[tail_reg]        <= bus.issue_pc;
      pred_jump_reg[tail_reg] <= bus.issue_pred_jump;
    end
    if (lsb_take) val_reg[bus.lsb_wb_pos] <= bus.lsb_wb_val;
    if (alu_take) begin
      val_reg[bus.alu_wb_pos]      <= bus.alu_wb_val;
      res_jump_reg[bus.alu_wb_pos] <= bus.alu_wb_jump;
      target_reg[bus.alu_wb_pos]   <= bus.alu_wb_target;
    end
  end

  // Dependency queries (rs1 = 0, rs2 = 1)
  logic [ROB_POS_W-1:0] q_pos [2];
  assign q_pos[0] = bus.rs1_pos;
  assign q_pos[1] = bus.rs2_pos;

  for (genvar gi = 0; gi < 2; gi++) begin : g_query
    logic            q_ready;
    logic [XLEN-1:0] q_val;
    always_comb begin
      q_ready = ready_reg[q_pos[gi]];
      q_val   = val_reg[q_pos[gi]];
`ifdef ROB_WB_BYPASS_EN
      if (lsb_take && (bus.lsb_wb_pos == q_pos[gi])) begin
        q_ready = 1'b1;
        q_val   = bus.lsb_wb_val;
      end
      if (alu_take && (bus.alu_wb_pos == q_pos[gi])) begin
        q_ready = 1'b1;
        q_val   = bus.alu_wb_val;
      end
`endif
    end
  end

  assign bus.rs1_ready   = g_query[0].q_ready;
  assign bus.rs1_val     = g_query[0].q_val;
  assign bus.rs2_ready   = g_query[1].q_ready;
  assign bus.rs2_val     = g_query[1].q_val;

  assign bus.full        = (count_reg == CNT_W'(DEPTH));
  assign bus.nxt_rob_pos = tail_reg;
  assign bus.cm_valid    = cm_valid_reg;
  assign bus.cm_pos      = {cm_pos_reg[1], cm_pos_reg[0]};
  assign bus.reg_we      = reg_we_reg;
  assign bus.reg_rd      = {reg_rd_reg[1], reg_rd_reg[0]};
  assign bus.reg_val     = {reg_val_reg[1], reg_val_reg[0]};
  assign bus.lsb_store   = lsb_store_reg;
  assign bus.br_commit   = br_commit_reg;
  assign bus.br_jump     = br_jump_reg;
  assign bus.br_pc       = br_pc_reg;
  assign bus.rollback    = rollback_reg;
  assign bus.set_pc_en   = set_pc_en_reg;
  assign bus.set_pc      = set_pc_reg;
endmodule
